// File: rtl/csa_cpa_resolve_pkg.sv
// Shared definitions for the carry-save resolve path.
// - res_width / seg_count: derive the result width and the number of
//   carry-propagate segments from the operand and segment widths.
// - csa32: one-bit 3:2 compressor. This block and the upstream CSA stage
//   both use it, so there is a single definition.
package csa_cpa_resolve_pkg;

   // Result width: three N-bit operands need two extra bits.
   function automatic int unsigned res_width(input int unsigned n);
      return n + 2;
   endfunction

   // Segment count: ceil(w / seg).
   function automatic int unsigned seg_count(input int unsigned w, input int unsigned seg);
      return (w + seg - 1) / seg;
   endfunction

   // 3:2 compressor for one bit column. Returns {carry, sum}.
   function automatic logic [1:0] csa32(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

endpackage

// File: rtl/csa_cpa_resolve_if.sv
// Operand/result handshake bundle for csa_cpa_resolve.
//   in_vec[3], in_tag, in_valid : operand side, driven by the producer
//   in_ready                    : block accepts an operand this cycle
//   out_sum, out_tag, out_valid : result side, driven by the block
//   out_ready                   : consumer accepts the result
// Modports: master is the producer/consumer view; slave is the block view.
interface csa_cpa_resolve_if #(
   parameter int unsigned N  = 64,
   parameter int unsigned TW = 8
);
   import csa_cpa_resolve_pkg::*;

   localparam int unsigned W = res_width(N);

   logic [N-1:0]  in_vec [3];
   logic [TW-1:0] in_tag;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_sum;
   logic [TW-1:0] out_tag;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output in_vec, in_tag, in_valid, out_ready,
      input  in_ready, out_sum, out_tag, out_valid
   );

   modport slave (
      input  in_vec, in_tag, in_valid, out_ready,
      output in_ready, out_sum, out_tag, out_valid
   );

endinterface

// File: rtl/cpa_segment.sv
// One segment of the carry-propagate adder. It adds two SW-bit slices and a
// carry-in, and registers both the SW-bit result and the carry-out.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : pipeline advance; registers hold while it is low
//   a, b, cin  : slice operands and the incoming carry
//   sum, cout  : registered slice result and carry-out
module cpa_segment #(
   parameter int unsigned SW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout
);

   logic [SW:0] total;

   // The carry chain spans exactly SW bits plus one adder.
   assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (en) begin
         {cout, sum} <= total;
      end
   end

endmodule

// File: rtl/csa_cpa_resolve.sv
// Resolves three redundant (carry-save) vectors into one binary sum.
// Stage 0 compresses the three vectors to sum/carry form. Stages 1..S then
// resolve the sum one SEG-bit segment per cycle. Bits already resolved, and
// the sum/carry bits still waiting, are skew-registered beside each segment.
// Every stage shifts on one global advance: adv = !out_valid || out_ready.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset; flushes all in-flight operands
//   bus   : slave view of csa_cpa_resolve_if (operand in, result out)
module csa_cpa_resolve
   import csa_cpa_resolve_pkg::*;
#(
   parameter int unsigned N   = 64,
   parameter int unsigned SEG = 16,
   parameter int unsigned TW  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   csa_cpa_resolve_if.slave    bus
);

   localparam int unsigned W = res_width(N);
   localparam int unsigned S = seg_count(W, SEG);

   logic          adv;
   logic [W-1:0]  s_c;
   logic [W-1:0]  c_c;

   // Unresolved sum/carry vectors. Stage k feeds segment k+1.
   logic [W-1:0]  st_s   [S];
   logic [W-1:0]  st_c   [S];
   // Resolved low bits registered beside segment k, excluding its own slice.
   logic [W-1:0]  st_res [1:S];
   // Resolved view after stage k: st_res[k] merged with segment k's slice.
   logic [W-1:0]  res_v  [0:S];
   logic [TW-1:0] st_tag [0:S];
   logic [S:0]    st_vld;
   logic          carry_v [S];
   logic          unused_cout;

   assign adv          = !st_vld[S] || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = st_vld[S];
   assign bus.out_tag   = st_tag[S];
   assign bus.out_sum   = res_v[S];

   // 3:2 compression. Carries move up one column, so bit 0 of c_c is zero.
   always_comb begin
      s_c = '0;
      c_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         {c_c[i+1], s_c[i]} = csa32(bus.in_vec[0][i], bus.in_vec[1][i], bus.in_vec[2][i]);
      end
   end

   assign res_v[0]   = '0;
   assign carry_v[0] = 1'b0;

   // One adder segment per stage. The top segment keeps only the bits left in W.
   for (genvar k = 1; k <= S; k++) begin : g_seg
      localparam int unsigned LO = (k - 1) * SEG;
      localparam int unsigned SW = (k == S) ? (W - LO) : SEG;

      logic [SW-1:0] sum_q;
      logic          cout_q;

      cpa_segment #(
         .SW (SW)
      ) u_cpa (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (adv),
         .a     (st_s[k-1][LO +: SW]),
         .b     (st_c[k-1][LO +: SW]),
         .cin   (carry_v[k-1]),
         .sum   (sum_q),
         .cout  (cout_q)
      );

      // The slice of st_res[k] that sum_q fills is still zero, so OR merges the two.
      assign res_v[k] = st_res[k] | (W'(sum_q) << LO);

      if (k < S) begin : g_carry
         assign carry_v[k] = cout_q;
      end else begin : g_drop
         // Nothing can carry out of the top segment; the result is exact in W bits.
         assign unused_cout = cout_q;
      end
   end

   // Stage registers: the valid bit, tag and skewed vectors move together on adv.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_vld <= '0;
         for (int unsigned k = 0; k <= S; k++) begin
            st_tag[k] <= '0;
         end
         for (int unsigned k = 0; k < S; k++) begin
            st_s[k] <= '0;
            st_c[k] <= '0;
         end
         for (int unsigned k = 1; k <= S; k++) begin
            st_res[k] <= '0;
         end
      end else if (adv) begin
         st_vld[0] <= bus.in_valid;
         st_tag[0] <= bus.in_tag;
         st_s[0]   <= s_c;
         st_c[0]   <= c_c;
         for (int unsigned k = 1; k <= S; k++) begin
            st_vld[k] <= st_vld[k-1];
            st_tag[k] <= st_tag[k-1];
            st_res[k] <= res_v[k-1];
         end
         for (int unsigned k = 1; k < S; k++) begin
            st_s[k] <= st_s[k-1];
            st_c[k] <= st_c[k-1];
         end
      end
   end

endmodule

// File: doc/csa_cpa_resolve.md
CSA_CPA_RESOLVE -- requirements
Module: csa_cpa_resolve

Interface
REQ-001 Parameter N, default 64: bit width of each carry-save input vector.
REQ-002 Parameter SEG, default 16: carry-propagate segment width in bits; legal range 4..N+2.
REQ-003 Parameter TW, default 8: sideband tag width in bits.
REQ-004 Localparam W = N+2 (result width); localparam S = ceil(W/SEG) (segment count).
REQ-005 clk  input  1  clock; single clock domain, rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 in_vec  input  [N-1:0] x3 (unpacked array)  three redundant vectors produced by a 6:3 CSA stage.
REQ-008 in_tag  input  TW  sideband tag travelling with the operand.
REQ-009 in_valid  input  1  operand present on in_vec/in_tag.
REQ-010 in_ready  output  1  block accepts the operand this cycle.
REQ-011 out_sum  output  W  binary sum in_vec[0]+in_vec[1]+in_vec[2], zero-extended, no truncation.
REQ-012 out_tag  output  TW  tag of the operand on out_sum.
REQ-013 out_valid  output  1  out_sum/out_tag hold a result.
REQ-014 out_ready  input  1  downstream accepts the result.

Function
REQ-015 Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-016 Stage 0 (registered): 3:2 compression into sum vector s and carry vector c<<1, both W bits.
REQ-017 Stages 1..S (registered): stage k adds segment k-1 of s and c plus the carry-in from stage k-1, producing SEG result bits and a carry-out.
REQ-018 Carry-in of stage 1 is 0; the last segment is truncated to W-(S-1)*SEG bits and its carry-out is discarded.
REQ-019 Already-resolved low segments and still-unresolved high segments are skew-registered alongside each stage; no combinational carry path spans more than SEG bits plus one adder.
REQ-020 Latency is exactly S+1 cycles from input transfer to out_valid when there is no stall (6 cycles at the defaults).
REQ-021 Throughput is one operand per cycle when out_ready is held high.
REQ-022 Each stage carries a valid bit; bubbles propagate as invalid stages.
REQ-023 Global advance enable: adv = !out_valid || out_ready; all stages shift only when adv=1.
REQ-024 in_ready = adv, combinational; in_ready does not depend on in_valid.
REQ-025 While adv=0 (stall), every stage register, including out_sum/out_tag/out_valid, is held unchanged.
REQ-026 Simultaneous input and output transfer in one cycle is legal; no operand is lost or duplicated.
REQ-027 Tags are emitted in acceptance order, paired with their own sums.
REQ-028 Arithmetic is exact: maximum result 3*(2^N-1) fits in W bits; no overflow indication is provided.

Reset
REQ-029 When rst_n=0 at a clock edge, all stage valid bits clear, out_valid=0, out_sum=0, out_tag=0.
REQ-030 A reset asserted mid-operation discards all in-flight operands; in_ready=1 on the first cycle after rst_n returns to 1.
REQ-031 Reset is sampled only on clk; there is no asynchronous path.

Structure
REQ-032 A shared package holds the W/S derivation function and the 3:2 compressor function, so the CSA stage and this block use one definition.
REQ-033 One sub-module, cpa_segment (SEG-bit adder with carry-in, registered carry-out and result), is instantiated S times via generate.
REQ-034 Target implementation size is 120-400 lines of RTL; no vendor primitives.

Verification
REQ-035 Reset then single operand {1,2,3}, tag 0x5A, out_ready=1 -> out_sum=6, tag 0x5A, exactly 6 cycles after acceptance.
REQ-036 All-ones operands {2^64-1 x3} -> out_sum=0x2_FFFF_FFFF_FFFF_FFFD; checks carry ripple across all 5 segments.
REQ-037 Back-to-back stream of 100 random operands with out_ready=1 -> one result per cycle, in order, matching a reference model.
REQ-038 Random out_ready (50%) with random in_valid -> no loss or duplication, out_sum/out_tag stable while out_valid && !out_ready, in_ready==(!out_valid||out_ready).
REQ-039 Reset asserted with 4 operands in flight -> out_valid=0 the next cycle; none of the flushed results ever appear.
REQ-040 Parameter sweep SEG in {4, 13, 66} with N=64 -> latencies 18, 7, 2 cycles respectively, and results exact.
